// File: rtl/erx_byte_decoder.sv
// erx_byte_decoder: receive-side elink byte decoder.
// Samples rx_frame/rx_data each clock and reassembles 104-bit emesh packets
// (13 bytes, LSB byte first) into an output FIFO that is drained through
// the rxwr_* access/wait interface.
// Optional feature: define ERX_BURST_EN to enable write-burst continuation.
// Ports:
//   clock, resetb          clock, asynchronous active-low reset
//   rx_frame, rx_data      wire frame marker and byte
//   rx_wait                backpressure to the remote transmitter
//   rxwr_access/packet     FIFO head valid / head packet
//   rxwr_wait              consumer stall (pop = access && !wait)
//   frame_err, overflow    sticky error flags, cleared by err_clear
module erx_byte_decoder #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WAIT_LEVEL = 2
) (
   input  logic         clock,
   input  logic         resetb,
   input  logic         rx_frame,
   input  logic [7:0]   rx_data,
   output logic         rx_wait,
   output logic         rxwr_access,
   output logic [103:0] rxwr_packet,
   input  logic         rxwr_wait,
   output logic         frame_err,
   output logic         overflow,
   input  logic         err_clear
);

   localparam int unsigned PKT_W = 104;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_DONE    = 3'd2;
   localparam logic [2:0] S_DISCARD = 3'd3;
`ifdef ERX_BURST_EN
   localparam logic [2:0] S_BURST   = 3'd4;
`endif

   logic [2:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [PKT_W-1:0] pkt_q, pkt_d;
   logic [6:0]       lsb;
   logic             push, err_ev;

   logic [PKT_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             acc_q, rx_wait_q, rx_wait_d;
   logic             frame_err_q, frame_err_d, overflow_q, overflow_d;
   logic             pop, full, push_ok, drop;

   // Packet assembly FSM; pkt_q also keeps the last pushed packet for bursts
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pkt_d   = pkt_q;
      lsb     = '0;
      push    = 1'b0;
      err_ev  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rx_frame) begin
               pkt_d[7:0] = rx_data;
               cnt_d      = 4'd1;
               state_d    = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (rx_frame) begin
               lsb              = {cnt_q, 3'b000};
               pkt_d[lsb +: 8]  = rx_data;
               cnt_d            = cnt_q + 4'd1;
               if (cnt_q == 4'd12) begin
                  push    = 1'b1;
                  cnt_d   = 4'd0;
                  state_d = S_DONE;
               end
            end else begin
               err_ev  = 1'b1;
               cnt_d   = 4'd0;
               state_d = S_IDLE;
            end
         end
         S_DONE: begin
            if (!rx_frame) begin
               state_d = S_IDLE;
`ifdef ERX_BURST_EN
            end else if (pkt_q[0] && (pkt_q[2:1] == 2'b10)) begin
               pkt_d[47:40] = rx_data;
               cnt_d        = 4'd1;
               state_d      = S_BURST;
`endif
            end else begin
               err_ev  = 1'b1;
               state_d = S_DISCARD;
            end
         end
`ifdef ERX_BURST_EN
         S_BURST: begin
            if (rx_frame) begin
               lsb             = 7'd40 + {2'b00, cnt_q[1:0], 3'b000};
               pkt_d[lsb +: 8] = rx_data;
               cnt_d           = cnt_q + 4'd1;
               if (cnt_q == 4'd3) begin
                  // dstaddr advances one word, wrapping at 2^32
                  pkt_d[39:8] = pkt_q[39:8] + 32'd4;
                  push        = 1'b1;
                  cnt_d       = 4'd0;
                  state_d     = S_DONE;
               end
            end else begin
               err_ev  = 1'b1;
               cnt_d   = 4'd0;
               state_d = S_IDLE;
            end
         end
`endif
         S_DISCARD: begin
            if (!rx_frame) state_d = S_IDLE;
         end
         default: begin
            cnt_d   = 4'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   // FIFO bookkeeping; a full FIFO still accepts a push when the head pops
   always_comb begin
      pop      = acc_q && !rxwr_wait;
      full     = (count_q == CNT_W'(FIFO_DEPTH));
      push_ok  = push && (!full || pop);
      drop     = push && full && !pop;
      wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      rx_wait_d   = (CNT_W'(FIFO_DEPTH) - count_q) <= CNT_W'(WAIT_LEVEL);
      // a same-cycle error event beats err_clear
      frame_err_d = err_ev ? 1'b1 : (err_clear ? 1'b0 : frame_err_q);
      overflow_d  = drop   ? 1'b1 : (err_clear ? 1'b0 : overflow_q);
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         pkt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         acc_q       <= 1'b0;
         rx_wait_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pkt_q       <= pkt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         acc_q       <= (count_d != '0);
         rx_wait_q   <= rx_wait_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
         if (push_ok) mem_q[wr_ptr_q] <= pkt_d;
      end
   end

   assign rxwr_access = acc_q;
   assign rxwr_packet = mem_q[rd_ptr_q];
   assign rx_wait     = rx_wait_q;
   assign frame_err   = frame_err_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_erx_byte_decoder.sv
// Directed testbench for erx_byte_decoder (FIFO_DEPTH=4, WAIT_LEVEL=2).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_erx_byte_decoder;

   logic         clock = 1'b0;
   logic         resetb;
   logic         rx_frame;
   logic [7:0]   rx_data;
   logic         rx_wait;
   logic         rxwr_access;
   logic [103:0] rxwr_packet;
   logic         rxwr_wait;
   logic         frame_err;
   logic         overflow;
   logic         err_clear;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   erx_byte_decoder #(.FIFO_DEPTH(4), .WAIT_LEVEL(2)) dut (
      .clock       (clock),
      .resetb      (resetb),
      .rx_frame    (rx_frame),
      .rx_data     (rx_data),
      .rx_wait     (rx_wait),
      .rxwr_access (rxwr_access),
      .rxwr_packet (rxwr_packet),
      .rxwr_wait   (rxwr_wait),
      .frame_err   (frame_err),
      .overflow    (overflow),
      .err_clear   (err_clear)
   );

   task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   // drives the 13 bytes of p with frame high; returns after the last byte is sampled
   task automatic send_pkt(input logic [103:0] p);
      for (int k = 0; k < 13; k++) begin
         rx_frame = 1'b1;
         rx_data  = p[8*k +: 8];
         step();
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) begin
         rx_frame = 1'b1;
         rx_data  = w[8*k +: 8];
         step();
      end
   endtask

   task automatic gap();
      rx_frame = 1'b0;
      rx_data  = 8'h00;
      step();
   endtask

   function automatic logic [103:0] mk(input logic [31:0] src, input logic [31:0] dat,
                                       input logic [31:0] dst, input logic [7:0] ctl);
      return {src, dat, dst, ctl};
   endfunction

   logic [103:0] p1, prd, pw, pexp [4];

   initial begin
      p1  = mk(32'h0, 32'hDEADBEEF, 32'h80800000, 8'h05);
      prd = mk(32'h0, 32'hDEADBEEF, 32'h80800000, 8'h04);
      resetb = 1'b0; rx_frame = 1'b0; rx_data = 8'h00; rxwr_wait = 1'b0; err_clear = 1'b0;
      step(); step();
      chk("rst_access",   104'(rxwr_access), 104'(0));
      chk("rst_packet",   rxwr_packet,       104'(0));
      chk("rst_rx_wait",  104'(rx_wait),     104'(0));
      chk("rst_frame_err",104'(frame_err),   104'(0));
      chk("rst_overflow", 104'(overflow),    104'(0));
      resetb = 1'b1;
      step();

      // single write, visible the cycle after the final byte
      send_pkt(p1);
      rx_frame = 1'b0;
      chk("single_access", 104'(rxwr_access), 104'(1));
      chk("single_packet", rxwr_packet,       p1);
      chk("single_ferr",   104'(frame_err),   104'(0));
      step();
      chk("single_popped", 104'(rxwr_access), 104'(0));

      // frame drop after 7 bytes
      for (int k = 0; k < 7; k++) begin
         rx_frame = 1'b1; rx_data = 8'h5A; step();
      end
      gap();
      chk("drop_ferr",   104'(frame_err),   104'(1));
      chk("drop_nopkt",  104'(rxwr_access), 104'(0));
      err_clear = 1'b1; step(); err_clear = 1'b0;
      chk("clear_ferr",  104'(frame_err),   104'(0));

`ifdef ERX_BURST_EN
      // write burst: three packets queued behind a stalled consumer
      rxwr_wait = 1'b1;
      send_pkt(p1);
      send_word(32'h11111111);
      send_word(32'h22222222);
      gap();
      chk("burst_ferr", 104'(frame_err), 104'(0));
      rxwr_wait = 1'b0;
      pexp[0] = p1;
      pexp[1] = mk(32'h0, 32'h11111111, 32'h80800004, 8'h05);
      pexp[2] = mk(32'h0, 32'h22222222, 32'h80800008, 8'h05);
      for (int i = 0; i < 3; i++) begin
         chk("burst_access", 104'(rxwr_access), 104'(1));
         chk("burst_packet", rxwr_packet, pexp[i]);
         step();
      end
      chk("burst_empty", 104'(rxwr_access), 104'(0));
      // dstaddr wrap
      rxwr_wait = 1'b1;
      pw = mk(32'h0, 32'h01020304, 32'hFFFFFFFC, 8'h05);
      send_pkt(pw);
      send_word(32'h33333333);
      gap();
      rxwr_wait = 1'b0;
      chk("wrap_first",  rxwr_packet, pw);
      step();
      chk("wrap_second", rxwr_packet, mk(32'h0, 32'h33333333, 32'h00000000, 8'h05));
      chk("wrap_ferr",   104'(frame_err), 104'(0));
      step();
`else
      // without burst support a continued write frame is an error
      rxwr_wait = 1'b1;
      send_pkt(p1);
      rx_frame = 1'b1; rx_data = 8'h11; step();
      chk("noburst_ferr",   104'(frame_err), 104'(1));
      chk("noburst_hold",   rxwr_packet,     p1);
      send_word(32'h11111111);
      gap();
      chk("noburst_single", rxwr_packet,     p1);
      rxwr_wait = 1'b0;
      step();
      chk("noburst_empty",  104'(rxwr_access), 104'(0));
      err_clear = 1'b1; step(); err_clear = 1'b0;
`endif

      // continuation after a read is always an error
      send_pkt(prd);
      chk("rdburst_access", 104'(rxwr_access), 104'(1));
      chk("rdburst_packet", rxwr_packet,       prd);
      rx_frame = 1'b1; rx_data = 8'h77; step();
      chk("rdburst_ferr",   104'(frame_err),   104'(1));
      send_word(32'h77777777);
      gap();
      chk("rdburst_nopkt",  104'(rxwr_access), 104'(0));
      chk("rdburst_sticky", 104'(frame_err),   104'(1));
      err_clear = 1'b1; step(); err_clear = 1'b0;
      chk("rdburst_clear",  104'(frame_err),   104'(0));

      // backpressure and overflow
      rxwr_wait = 1'b1;
      for (int i = 0; i < 4; i++)
         pexp[i] = mk(32'h10000000 + 32'(i), 32'hA5A50000 + 32'(i), 32'h20000000 + 32'(16*i), 8'h00);
      send_pkt(pexp[0]);
      gap();
      chk("bp_wait_1", 104'(rx_wait), 104'(0));
      send_pkt(pexp[1]);
      chk("bp_wait_lag", 104'(rx_wait), 104'(0));
      gap();
      chk("bp_wait_2", 104'(rx_wait), 104'(1));
      send_pkt(pexp[2]);
      gap();
      send_pkt(pexp[3]);
      chk("bp_no_ovf", 104'(overflow), 104'(0));
      gap();
      send_pkt(mk(32'hBAD, 32'hBAD, 32'hBAD, 8'h00));
      chk("bp_ovf", 104'(overflow), 104'(1));
      gap();
      rxwr_wait = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("bp_access", 104'(rxwr_access), 104'(1));
         chk("bp_packet", rxwr_packet,       pexp[i]);
         step();
      end
      chk("bp_empty", 104'(rxwr_access), 104'(0));
      step();
      chk("bp_wait_off", 104'(rx_wait), 104'(0));
      chk("bp_ovf_sticky", 104'(overflow), 104'(1));

      // asynchronous reset in the middle of a packet
      rxwr_wait = 1'b1;
      send_pkt(pexp[2]);
      gap();
      chk("mid_pre_access", 104'(rxwr_access), 104'(1));
      for (int k = 0; k < 6; k++) begin
         rx_frame = 1'b1; rx_data = pexp[3][8*k +: 8]; step();
      end
      rx_data = pexp[3][55:48];
      #2 resetb = 1'b0;
      #1;
      chk("mid_access", 104'(rxwr_access), 104'(0));
      chk("mid_packet", rxwr_packet,       104'(0));
      chk("mid_ovf",    104'(overflow),    104'(0));
      chk("mid_ferr",   104'(frame_err),   104'(0));
      chk("mid_wait",   104'(rx_wait),     104'(0));
      step();
      rx_frame = 1'b0; resetb = 1'b1; rxwr_wait = 1'b0;
      step();
      send_pkt(p1);
      rx_frame = 1'b0;
      chk("post_access", 104'(rxwr_access), 104'(1));
      chk("post_packet", rxwr_packet,       p1);
      chk("post_ferr",   104'(frame_err),   104'(0));
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/erx_byte_decoder.md
Name: erx_byte_decoder

Overview:
Receive-side decoder for the byte-wide elink wire protocol. It samples rx_frame/rx_data once per clock and reassembles 104-bit emesh packets, including write bursts, into an output FIFO. The FIFO drains through a standard access/wait packet interface (rxwr_*). The block drives rx_wait back to the remote transmitter and is the counterpart of the tx serializer feeding txo_frame/txo_data.

Parameters:
FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 4.
WAIT_LEVEL, 2, rx_wait asserts when free FIFO entries <= WAIT_LEVEL.

Ports:
clock  input  1  sole clock; everything samples on rising edge
resetb  input  1  asynchronous reset, active low
rx_frame  input  1  frame marker; each cycle with rx_frame=1 carries one valid byte
rx_data  input  8  wire byte
rx_wait  output  1  backpressure to remote transmitter
rxwr_access  output  1  FIFO head valid
rxwr_packet  output  104  FIFO head packet
rxwr_wait  input  1  consumer stall; pop occurs when rxwr_access && !rxwr_wait
frame_err  output  1  sticky framing error
overflow  output  1  sticky packet-dropped flag
err_clear  input  1  synchronous clear of frame_err and overflow

Behaviour:
- Packet layout: [0] write, [2:1] datamode, [7:3] ctrlmode, [39:8] dstaddr, [71:40] data, [103:72] srcaddr.
- Wire order: byte k carries packet[8k+7:8k], k=0..12, LSB byte first.
- Reset (resetb=0, asynchronous): state IDLE, byte counter 0, FIFO empty. rxwr_access=0, rxwr_packet=0, rx_wait=0, frame_err=0, overflow=0.
- FSM states:
  - IDLE: rx_frame=1 -> capture byte 0, cnt=1, go COLLECT.
  - COLLECT: rx_frame=1 -> capture byte cnt, cnt++. When byte 12 is captured, push the packet and go DONE. rx_frame=0 before byte 12 -> discard partial packet, set frame_err, go IDLE.
  - DONE: rx_frame=0 -> IDLE. rx_frame=1 with last packet write=1 and datamode=2'b10 -> burst: capture byte as data[7:0], cnt=1, go BURST. rx_frame=1 otherwise -> set frame_err, go DISCARD.
  - BURST: capture data byte cnt (LSB first). On the 4th byte, push a packet whose dstaddr = previous dstaddr + 4 (mod 2^32, wraps silently). All other fields are copied from the previous packet. Then go DONE. rx_frame=0 mid-burst -> discard, set frame_err, go IDLE.
  - DISCARD: ignore bytes until rx_frame=0, then IDLE.
- Latency: packet visible on rxwr_access/rxwr_packet on the cycle after its final byte is sampled, if the FIFO was empty (first-word-fall-through registered head).
- FIFO rules:
  - Push when full with no same-cycle pop: packet dropped, overflow set.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Pop when empty: ignored.
  - rxwr_packet holds its value while rxwr_access=1 && rxwr_wait=1.
- rx_wait is registered from the FIFO count: 1 when (FIFO_DEPTH - count) <= WAIT_LEVEL. It updates one cycle after the count changes. The decoder never stalls on rx_wait; the remote side honours it.
- err_clear: clears both sticky flags next cycle. A same-cycle error event wins; the flag stays 1.
- Sticky flags do not affect decoding.

Optional Feature:
ERX_BURST_EN
- Defined: burst continuation as described in DONE/BURST.
- Undefined: BURST state is absent. In DONE, rx_frame=1 always sets frame_err and goes DISCARD, regardless of write/datamode.

Test Plan:
- Single write: bytes 0x05, 00 00 80 80, EF BE AD DE, 00 00 00 00 (13 cycles), then frame low -> one cycle later rxwr_access=1, rxwr_packet = {32'h0, 32'hDEADBEEF, 32'h80800000, 8'h05}; frame_err=0.
- Burst (ERX_BURST_EN): the same 13 bytes, then frame held high for 8 more bytes 11 11 11 11 22 22 22 22 -> three packets: dstaddr 0x80800000/04/08, data DEADBEEF/11111111/22222222.
- Burst wrap: dstaddr 0xFFFFFFFC, one burst word -> second packet dstaddr 0x00000000, no error.
- Frame drop after 7 bytes -> no packet, frame_err=1. err_clear pulse -> frame_err=0 next cycle.
- Burst attempt on a read (byte0=0x04) -> first packet delivered, frame_err=1, following bytes ignored until frame low.
- Backpressure: FIFO_DEPTH=4, WAIT_LEVEL=2, rxwr_wait=1, send 5 packets -> rx_wait=1 after 2nd push; 5th packet dropped, overflow=1. Release rxwr_wait -> 4 packets delivered in order.
- Reset mid-packet: assert resetb=0 at byte 6 -> all outputs 0 immediately. After release, a fresh 13-byte packet decodes correctly.
